// File: rtl/mem_port_sequencer_pkg.sv
// Shared encodings for the memory port sequencer: FSM states, grant sides, bus constants.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } seq_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DT = 1'b1
    } gnt_t;

    // READ_WRITE / WORD_BYTE encodings as seen by external memory
    localparam logic RW_READ = 1'b1;
    localparam logic WB_WORD = 1'b1;

endpackage

// File: rtl/mem_port_sequencer_if.sv
// External memory port bundle: address, strobes, write data out, read data and MFC in.
// Latency: wires only; timing is owned by whichever side drives each signal.
// Backpressure: MFA/MFC handshake, MFA holds until memory answers with MFC.
interface mem_port_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] MEMADD;
    logic              MFA;
    logic              READ_WRITE;
    logic              WORD_BYTE;
    logic [DATA_W-1:0] MEMDAT_OUT;
    logic              MEMDAT_OE;
    logic [DATA_W-1:0] MEMDAT_IN;
    logic              MFC;

    modport master (
        output MEMADD, MFA, READ_WRITE, WORD_BYTE, MEMDAT_OUT, MEMDAT_OE,
        input  MEMDAT_IN, MFC
    );

    modport slave (
        input  MEMADD, MFA, READ_WRITE, WORD_BYTE, MEMDAT_OUT, MEMDAT_OE,
        output MEMDAT_IN, MFC
    );
endinterface

// File: rtl/mem_port_sequencer_arbiter.sv
// Two-input alternating-priority arbiter between fetch and data requesters.
// Latency: combinational grant; last_grant updates on the edge a grant is taken.
// Backpressure: grants only while en is high; losing requester simply keeps its level request.
module mem_port_arbiter
    import mem_seq_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    input  logic if_req,
    input  logic dt_req,
    output logic gnt_vld,
    output gnt_t gnt_sel
);

    gnt_t last_grant;

    // Pick the lone requester, or on contention the side that did not win last time
    always_comb begin
        gnt_vld = en && (if_req || dt_req);
        gnt_sel = GNT_IF;
        if (if_req && dt_req) begin
            if (last_grant == GNT_IF) begin
                gnt_sel = GNT_DT;
            end else begin
                gnt_sel = GNT_IF;
            end
        end else if (dt_req) begin
            gnt_sel = GNT_DT;
        end
    end

    // Remember the winner so the next contention flips priority
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_grant <= GNT_IF;
        end else if (gnt_vld) begin
            last_grant <= gnt_sel;
        end
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Owns the external memory port: arbitrates fetch vs data, runs MFA/MFC, returns read data. Optional MEM_TIMEOUT_EN aborts stalled accesses.
// Latency: MFA rises the edge after a grant; done/rdata the edge MFC is sampled; one RECOVER cycle follows.
// Backpressure: requesters hold level req until their done pulse; BUSY waits on MFC (or timeout when enabled).
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              dt_req,
    input  logic [ADDR_W-1:0] dt_addr,
    input  logic              dt_rw,
    input  logic              dt_wb,
    input  logic [DATA_W-1:0] dt_wdata,
    output logic              dt_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    mem_port_sequencer_if.master mem
);

    seq_state_t state;
    gnt_t       cur_gnt;
    logic       gnt_vld;
    gnt_t       gnt_sel;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    mem_port_arbiter u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .en      (state == IDLE),
        .if_req  (if_req),
        .dt_req  (dt_req),
        .gnt_vld (gnt_vld),
        .gnt_sel (gnt_sel)
    );

    // Access sequencer: latch on grant, hold MFA through BUSY, one dead cycle in RECOVER
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state          <= IDLE;
            cur_gnt        <= GNT_IF;
            mem.MFA        <= 1'b0;
            mem.MEMDAT_OE  <= 1'b0;
            mem.MEMADD     <= '0;
            mem.MEMDAT_OUT <= '0;
            mem.READ_WRITE <= RW_READ;
            mem.WORD_BYTE  <= WB_WORD;
            rdata          <= '0;
            if_done        <= 1'b0;
            dt_done        <= 1'b0;
            err            <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            // done/err are single-cycle pulses
            if_done <= 1'b0;
            dt_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        cur_gnt <= gnt_sel;
                        mem.MFA <= 1'b1;
                        state   <= BUSY;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (gnt_sel == GNT_IF) begin
                            // fetches are always word reads
                            mem.MEMADD     <= if_addr;
                            mem.READ_WRITE <= RW_READ;
                            mem.WORD_BYTE  <= WB_WORD;
                            mem.MEMDAT_OE  <= 1'b0;
                        end else begin
                            mem.MEMADD     <= dt_addr;
                            mem.READ_WRITE <= dt_rw;
                            mem.WORD_BYTE  <= dt_wb;
                            mem.MEMDAT_OUT <= dt_wdata;
                            mem.MEMDAT_OE  <= (dt_rw != RW_READ);
                        end
                    end
                end
                BUSY: begin
                    if (mem.MFC) begin
                        // normal completion wins over a coincident timeout
                        if (mem.READ_WRITE == RW_READ) begin
                            rdata <= mem.MEMDAT_IN;
                        end
                        mem.MFA       <= 1'b0;
                        mem.MEMDAT_OE <= 1'b0;
                        if (cur_gnt == GNT_IF) begin
                            if_done <= 1'b1;
                        end else begin
                            dt_done <= 1'b1;
                        end
                        state <= RECOVER;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // abort: rdata untouched, requester sees done with err
                        mem.MFA       <= 1'b0;
                        mem.MEMDAT_OE <= 1'b0;
                        err           <= 1'b1;
                        if (cur_gnt == GNT_IF) begin
                            if_done <= 1'b1;
                        end else begin
                            dt_done <= 1'b1;
                        end
                        state <= RECOVER;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                RECOVER: begin
                    // guarantees MFA low for a full cycle between accesses
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Scoreboard bench for mem_port_sequencer: expected accesses queued at drive time, checked at MFA and done.
// Latency: memory model answers MFC after mfc_delay BUSY cycles, or continuously when stuck.
// Backpressure: requesters hold req until the bench has seen the requested number of done pulses.
module tb_mem_port_sequencer;
    import mem_seq_pkg::*;

    typedef struct {
        logic        side;   // 0 = fetch, 1 = data
        logic [7:0]  addr;
        logic        rw;
        logic        wb;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_done;
    logic        dt_req = 1'b0;
    logic [7:0]  dt_addr = '0;
    logic        dt_rw = 1'b1;
    logic        dt_wb = 1'b1;
    logic [31:0] dt_wdata = '0;
    logic        dt_done;
    logic [31:0] rdata;
    logic        err;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] mon_exp;
    int          mfc_delay = 3;
    bit          mfc_stuck = 1'b0;
    int          busy_cnt = 0;
    int          last_len = 0;
    int          cyc = 0;
    int          g_prev = 0;
    int          g_last = 0;

    always #5 Clk = ~Clk;

    mem_port_sequencer_if mif ();

    mem_port_sequencer #(
        .ADDR_W (8),
        .DATA_W (32)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT(4)
`endif
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .dt_req   (dt_req),
        .dt_addr  (dt_addr),
        .dt_rw    (dt_rw),
        .dt_wb    (dt_wb),
        .dt_wdata (dt_wdata),
        .dt_done  (dt_done),
        .rdata    (rdata),
        .err      (err),
        .mem      (mif.master)
    );

    function automatic logic [31:0] mem_model(input logic [7:0] a);
        if (a == 8'h10) return 32'hE3A01005;
        return {a, 8'hA5, ~a, a ^ 8'h3C};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge Clk) cyc++;

    // Memory model + port checker + done scoreboard, all sampled mid-cycle
    always @(negedge Clk) begin
        if (mif.MFA) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
                g_prev = g_last;
                g_last = cyc;
            end
            if (sb.size() > 0) begin
                check("memadd", mif.MEMADD, sb[0].addr);
                check("read_write", mif.READ_WRITE, sb[0].rw);
                check("word_byte", mif.WORD_BYTE, sb[0].wb);
                check("memdat_oe", mif.MEMDAT_OE, !sb[0].rw);
                if (!sb[0].rw) check("memdat_out", mif.MEMDAT_OUT, sb[0].wdata);
            end else begin
                check("mfa_unexpected", mif.MFA, 1'b0);
            end
        end else begin
            if (busy_cnt > 0) last_len = busy_cnt;
            busy_cnt = 0;
        end
        mif.MFC       = mfc_stuck || (mif.MFA && busy_cnt == mfc_delay);
        mif.MEMDAT_IN = mem_model(mif.MEMADD);
        if (if_done || dt_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {if_done, dt_done}, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                check("both_done", if_done && dt_done, 1'b0);
                check("done_side", dt_done, mon_e.side);
                check("err", err, mon_e.err);
                mon_exp = (mon_e.rw && !mon_e.err) ? mon_e.rd : last_rd;
                check("rdata", rdata, mon_exp);
                if (mon_e.rw && !mon_e.err) last_rd = mon_e.rd;
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        tick();
        sb.delete();
        last_rd = '0;
        Reset = 1'b1;
    endtask

    // Wait for n done pulses within budget cycles, then release both requesters
    task automatic wait_dones(input string tag, input int n, input int budget);
        int got = 0;
        int k = 0;
        while (got < n && k < budget) begin
            tick();
            k++;
            if (if_done || dt_done) got++;
        end
        if_req = 1'b0;
        dt_req = 1'b0;
        check({tag, "_ndone"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        // reset state
        Reset = 1'b0;
        repeat (3) tick();
        check("rst_mfa", mif.MFA, 1'b0);
        check("rst_oe", mif.MEMDAT_OE, 1'b0);
        check("rst_if_done", if_done, 1'b0);
        check("rst_dt_done", dt_done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_memadd", mif.MEMADD, 8'h00);
        check("rst_memdat_out", mif.MEMDAT_OUT, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rw", mif.READ_WRITE, 1'b1);
        check("rst_wb", mif.WORD_BYTE, 1'b1);
        Reset = 1'b1;
        tick();

        // fetch read, MFC after 3 BUSY cycles
        mfc_delay = 3;
        sb.push_back('{1'b0, 8'h10, 1'b1, 1'b1, 32'h0, 32'hE3A01005, 1'b0});
        if_addr = 8'h10;
        if_req  = 1'b1;
        wait_dones("t1", 1, 50);
        check("t1_mfa_len", last_len, 3);
        check("t1_rdata_hold", rdata, 32'hE3A01005);

        // byte store; rdata must keep the fetched word
        sb.push_back('{1'b1, 8'h2C, 1'b0, 1'b0, 32'h000000AB, 32'h0, 1'b0});
        dt_addr = 8'h2C; dt_rw = 1'b0; dt_wb = 1'b0; dt_wdata = 32'h000000AB;
        dt_req = 1'b1;
        wait_dones("t2", 1, 50);
        check("t2_mfa_len", last_len, 3);
        check("t2_rdata_unchanged", rdata, 32'hE3A01005);
        tick();

        // contention from reset: dt, if, dt, if
        do_reset();
        mfc_delay = 1;
        dt_addr = 8'h41; dt_rw = 1'b1; dt_wb = 1'b1;
        if_addr = 8'h40;
        sb.push_back('{1'b1, 8'h41, 1'b1, 1'b1, 32'h0, mem_model(8'h41), 1'b0});
        sb.push_back('{1'b0, 8'h40, 1'b1, 1'b1, 32'h0, mem_model(8'h40), 1'b0});
        sb.push_back('{1'b1, 8'h41, 1'b1, 1'b1, 32'h0, mem_model(8'h41), 1'b0});
        sb.push_back('{1'b0, 8'h40, 1'b1, 1'b1, 32'h0, mem_model(8'h40), 1'b0});
        if_req = 1'b1;
        dt_req = 1'b1;
        wait_dones("t3", 4, 100);
        check("t3_spacing", g_last - g_prev, 3);
        check("t3_mfa_len", last_len, 1);
        check("t3_sb_empty", sb.size(), 0);
        tick();

        // reset in the second BUSY cycle
        mfc_delay = 10;
        sb.push_back('{1'b1, 8'h33, 1'b1, 1'b1, 32'h0, mem_model(8'h33), 1'b0});
        dt_addr = 8'h33;
        dt_req = 1'b1;
        k = 0;
        while (!mif.MFA && k < 20) begin
            tick();
            k++;
        end
        check("t4_mfa_up", mif.MFA, 1'b1);
        tick();
        Reset = 1'b0;
        tick();
        check("t4_mfa_after_rst", mif.MFA, 1'b0);
        check("t4_no_dt_done", dt_done, 1'b0);
        check("t4_no_if_done", if_done, 1'b0);
        check("t4_memadd", mif.MEMADD, 8'h00);
        dt_req = 1'b0;
        sb.delete();
        last_rd = '0;
        Reset = 1'b1;
        mfc_stuck = 1'b1;
        repeat (5) tick();
        check("t4_mfc_ignored", mif.MFA, 1'b0);

        // MFC stuck high across two fetches
        sb.push_back('{1'b0, 8'h20, 1'b1, 1'b1, 32'h0, mem_model(8'h20), 1'b0});
        sb.push_back('{1'b0, 8'h20, 1'b1, 1'b1, 32'h0, mem_model(8'h20), 1'b0});
        if_addr = 8'h20;
        if_req = 1'b1;
        wait_dones("t5", 2, 50);
        check("t5_spacing", g_last - g_prev, 3);
        check("t5_mfa_len", last_len, 1);
        repeat (4) tick();
        check("t5_idle_mfa", mif.MFA, 1'b0);
        mfc_stuck = 1'b0;
        tick();

        // memory never answers
        mfc_delay = 1000;
        dt_addr = 8'h55; dt_rw = 1'b1; dt_wb = 1'b1;
`ifdef MEM_TIMEOUT_EN
        sb.push_back('{1'b1, 8'h55, 1'b1, 1'b1, 32'h0, mem_model(8'h55), 1'b1});
        dt_req = 1'b1;
        wait_dones("t6", 1, 50);
        check("t6_mfa_len", last_len, 4);
        check("t6_mfa_low", mif.MFA, 1'b0);
        check("t6_rdata_unchanged", rdata, mem_model(8'h20));
`else
        sb.push_back('{1'b1, 8'h55, 1'b1, 1'b1, 32'h0, mem_model(8'h55), 1'b0});
        dt_req = 1'b1;
        repeat (20) tick();
        check("t6_mfa_held", mif.MFA, 1'b1);
        check("t6_err", err, 1'b0);
        check("t6_no_done", dt_done, 1'b0);
        dt_req = 1'b0;
        do_reset();
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
